// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: run-time configurable hardware performance-monitor counters.
// Each counter picks one 2-bit event increment through its selector, can be inhibited,
// and is reached through a single-cycle SRAM-like CSR port.
// Optional feature macro: HPM_OVF_IRQ_EN enables the sticky overflow status,
// the interrupt enable and ovf_irq_o. Without it, counters still wrap silently.
module hpm_counter_bank #(
    parameter int unsigned NUM_COUNTERS = 8,
    parameter int unsigned NUM_EVENTS   = 16,
    parameter int unsigned CNT_WIDTH    = 64,
    parameter int unsigned XLEN         = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    debug_mode_i,
    input  logic [5:0]              addr_i,
    input  logic                    we_i,
    input  logic [XLEN-1:0]         data_i,
    output logic [XLEN-1:0]         data_o,
    input  logic [2*NUM_EVENTS-1:0] event_inc_i,
    output logic                    ovf_irq_o
);

    localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

    logic [1:0]              grp;
    logic [3:0]              idx;
    logic [63:0]             cnt_ext [16];
    logic [XLEN-1:0]         sel_ext [16];
    logic [NUM_COUNTERS-1:0] ovf_set;
    logic [NUM_COUNTERS-1:0] inhibit;
    logic [XLEN-1:0]         ovf_status_rd;
    logic [XLEN-1:0]         ovf_en_rd;

    assign grp = addr_i[5:4];
    assign idx = addr_i[3:0];

    // Slots beyond NUM_COUNTERS read as zero and ignore writes.
    for (genvar g = 0; g < 16; g++) begin : gen_slot
        if (g < NUM_COUNTERS) begin : gen_cnt
            logic [CNT_WIDTH-1:0] cnt;
            logic [CNT_WIDTH-1:0] cnt_next;
            logic [SEL_W-1:0]     sel;
            logic [1:0]           inc;
            logic [CNT_WIDTH:0]   sum;
            logic [63:0]          wr_val;
            logic                 wr_lo;
            logic                 wr_hi;
            logic                 wr_sel;
            logic                 ovf;

            assign wr_lo  = we_i && (grp == 2'b00) && (idx == 4'(g));
            assign wr_hi  = (XLEN == 32) && we_i && (grp == 2'b01) && (idx == 4'(g));
            assign wr_sel = we_i && (grp == 2'b10) && (idx == 4'(g));

            // Select this counter's increment; selector 0 or beyond NUM_EVENTS counts nothing.
            always_comb begin
                inc = 2'b00;
                for (int k = 0; k < NUM_EVENTS; k++) begin
                    if (sel == SEL_W'(k + 1)) inc = event_inc_i[2*k +: 2];
                end
            end

            // Next count: a software write replaces its half and drops this cycle's increment.
            always_comb begin
                sum      = {1'b0, cnt} + (CNT_WIDTH + 1)'(inc);
                wr_val   = 64'(cnt);
                cnt_next = cnt;
                ovf      = 1'b0;
                if (wr_lo || wr_hi) begin
                    if (wr_lo) wr_val[XLEN-1:0] = data_i;
                    if (wr_hi) wr_val[63:32] = data_i[31:0];
                    cnt_next = wr_val[CNT_WIDTH-1:0];
                end else if (!debug_mode_i && !inhibit[g]) begin
                    cnt_next = sum[CNT_WIDTH-1:0];
                    ovf      = sum[CNT_WIDTH];
                end
            end

            // Counter and event selector registers.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt <= '0;
                    sel <= '0;
                end else begin
                    cnt <= cnt_next;
                    if (wr_sel) sel <= data_i[SEL_W-1:0];
                end
            end

            assign cnt_ext[g] = 64'(cnt);
            assign sel_ext[g] = XLEN'(sel);
            assign ovf_set[g] = ovf;
        end else begin : gen_empty
            assign cnt_ext[g] = '0;
            assign sel_ext[g] = '0;
        end
    end

    // Inhibit mask register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inhibit <= '0;
        end else if (we_i && (addr_i == 6'h30)) begin
            inhibit <= data_i[NUM_COUNTERS-1:0];
        end
    end

`ifdef HPM_OVF_IRQ_EN
    logic [NUM_COUNTERS-1:0] ovf_status;
    logic [NUM_COUNTERS-1:0] ovf_en;

    // Sticky overflow status (write-1-to-clear, a fresh overflow wins) and interrupt enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_status <= '0;
            ovf_en     <= '0;
        end else begin
            if (we_i && (addr_i == 6'h31)) begin
                ovf_status <= (ovf_status & ~data_i[NUM_COUNTERS-1:0]) | ovf_set;
            end else begin
                ovf_status <= ovf_status | ovf_set;
            end
            if (we_i && (addr_i == 6'h32)) ovf_en <= data_i[NUM_COUNTERS-1:0];
        end
    end

    assign ovf_irq_o     = |(ovf_status & ovf_en);
    assign ovf_status_rd = XLEN'(ovf_status);
    assign ovf_en_rd     = XLEN'(ovf_en);
`else
    logic unused_ovf_set;
    assign unused_ovf_set = ^ovf_set;
    assign ovf_irq_o      = 1'b0;
    assign ovf_status_rd  = '0;
    assign ovf_en_rd      = '0;
`endif

    // Combinational read of current state; a same-cycle write is not yet visible.
    always_comb begin
        data_o = '0;
        case (grp)
            2'b00: data_o = cnt_ext[idx][XLEN-1:0];
            2'b01: if (XLEN == 32) data_o = XLEN'(cnt_ext[idx][63:32]);
            2'b10: data_o = sel_ext[idx];
            default: begin
                case (idx)
                    4'd0:    data_o = XLEN'(inhibit);
                    4'd1:    data_o = ovf_status_rd;
                    4'd2:    data_o = ovf_en_rd;
                    default: data_o = '0;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: a default 64-bit instance and a 32-bit CSR instance.
module tb_hpm_counter_bank;

    localparam int unsigned NE = 16;
`ifdef HPM_OVF_IRQ_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dbg = 1'b0;
    logic [5:0]    addr = '0;
    logic [5:0]    addr32 = '0;
    logic          we = 1'b0;
    logic          we32 = 1'b0;
    logic [63:0]   wdata = '0;
    logic [31:0]   wdata32 = '0;
    logic [63:0]   rdata;
    logic [31:0]   rdata32;
    logic [2*NE-1:0] ev = '0;
    logic [7:0]    ev32 = '0;
    logic          irq;
    logic          irq32;

    always #5 clk = ~clk;

    hpm_counter_bank dut (
        .clk_i(clk), .rst_i(rst), .debug_mode_i(dbg), .addr_i(addr), .we_i(we),
        .data_i(wdata), .data_o(rdata), .event_inc_i(ev), .ovf_irq_o(irq)
    );

    hpm_counter_bank #(
        .NUM_COUNTERS(4), .NUM_EVENTS(4), .CNT_WIDTH(64), .XLEN(32)
    ) dut32 (
        .clk_i(clk), .rst_i(rst), .debug_mode_i(1'b0), .addr_i(addr32), .we_i(we32),
        .data_i(wdata32), .data_o(rdata32), .event_inc_i(ev32), .ovf_irq_o(irq32)
    );

    typedef struct {
        string       name;
        bit          which;
        bit          is_irq;
        logic [63:0] exp;
    } chk_t;

    chk_t sb[$];
    logic chk_req = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: whenever a check is presented, pop the expected entry and compare.
    initial begin : monitor
        chk_t        c;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: no expected entry for presented check");
                end else begin
                    c = sb.pop_front();
                    if (c.is_irq) act = c.which ? 64'(irq32) : 64'(irq);
                    else          act = c.which ? 64'(rdata32) : rdata;
                    if (act !== c.exp) begin
                        n_err++;
                        $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
                    end
                end
            end
        end
    end

    task automatic bus(input bit which, input logic [5:0] a, input bit w, input logic [63:0] d,
                       input bit chk, input bit is_irq, input logic [63:0] exp, input string nm);
        chk_t c;
        if (which) begin
            addr32 = a; we32 = w; wdata32 = d[31:0];
        end else begin
            addr = a; we = w; wdata = d;
        end
        if (chk) begin
            c.name = nm; c.which = which; c.is_irq = is_irq; c.exp = exp;
            sb.push_back(c);
            chk_req = 1'b1;
        end
        @(posedge clk);
        #1;
        we = 1'b0; we32 = 1'b0; chk_req = 1'b0;
    endtask

    task automatic wr(input bit which, input logic [5:0] a, input logic [63:0] d);
        bus(which, a, 1'b1, d, 1'b0, 1'b0, 64'd0, "");
    endtask

    task automatic rd(input bit which, input logic [5:0] a, input logic [63:0] exp,
                      input string nm);
        bus(which, a, 1'b0, 64'd0, 1'b1, 1'b0, exp, nm);
    endtask

    task automatic irq_chk(input bit which, input logic exp, input string nm);
        bus(which, 6'h3f, 1'b0, 64'd0, 1'b1, 1'b1, {63'd0, exp}, nm);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every address.
        for (int a = 0; a < 64; a++) rd(0, 6'(a), 64'd0, $sformatf("reset read 0x%0h", a));
        irq_chk(0, 1'b0, "reset irq");
        irq_chk(1, 1'b0, "reset irq32");

        // Selector[2] = 5 (event 4), increment 2 for 10 cycles.
        wr(0, 6'h22, 64'd5);
        ev[9:8] = 2'd2;
        repeat (10) idle();
        ev = '0;
        rd(0, 6'h02, 64'd20, "cnt2 after 10x2");
        rd(0, 6'h00, 64'd0, "cnt0 unselected");
        rd(0, 6'h22, 64'd5, "sel2 readback");

        // Counter[1] wrap-around with overflow interrupt.
        wr(0, 6'h01, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(0, 6'h32, 64'h2);
        wr(0, 6'h21, 64'd1);
        ev[1:0] = 2'd3;
        rd(0, 6'h01, 64'hFFFF_FFFF_FFFF_FFFF, "cnt1 pre-wrap");
        ev = '0;
        rd(0, 6'h01, 64'd2, "cnt1 wrapped");
        irq_chk(0, OVF, "irq after wrap");
        rd(0, 6'h31, OVF ? 64'h2 : 64'h0, "ovf status after wrap");
        wr(0, 6'h31, 64'h2);
        irq_chk(0, 1'b0, "irq after w1c");
        rd(0, 6'h31, 64'd0, "ovf status cleared");

        // Counter[3]: write wins over a same-cycle increment; read shows pre-write value.
        wr(0, 6'h23, 64'd1);
        ev[1:0] = 2'd1;
        idle();
        bus(0, 6'h03, 1'b1, 64'h100, 1'b1, 1'b0, 64'd1, "cnt3 read during write");
        rd(0, 6'h03, 64'h100, "cnt3 write wins");
        ev = '0;
        rd(0, 6'h03, 64'h101, "cnt3 resumes");

        // Inhibit and debug freeze counter[0].
        wr(0, 6'h20, 64'd1);
        wr(0, 6'h30, 64'd1);
        ev[1:0] = 2'd1;
        repeat (5) idle();
        rd(0, 6'h00, 64'd0, "cnt0 inhibited");
        ev = '0;
        wr(0, 6'h30, 64'd0);
        dbg = 1'b1;
        ev[1:0] = 2'd1;
        repeat (5) idle();
        rd(0, 6'h00, 64'd0, "cnt0 debug frozen");
        wr(0, 6'h00, 64'd7);
        rd(0, 6'h00, 64'd7, "cnt0 write in debug");
        dbg = 1'b0;
        repeat (3) idle();
        rd(0, 6'h00, 64'd10, "cnt0 resumed");
        ev = '0;
        rd(0, 6'h00, 64'd11, "cnt0 +1 per cycle");

        // Reserved addresses and out-of-range counters ignore writes.
        wr(0, 6'h0A, 64'd5);
        rd(0, 6'h0A, 64'd0, "cnt10 out of range");
        wr(0, 6'h10, 64'd5);
        rd(0, 6'h10, 64'd0, "high half reserved at XLEN 64");
        wr(0, 6'h33, 64'd5);
        rd(0, 6'h33, 64'd0, "ctrl 0x33 reserved");
        wr(0, 6'h2A, 64'd3);
        rd(0, 6'h2A, 64'd0, "sel10 out of range");

        // Selector bounds: above NUM_EVENTS counts nothing; upper write bits dropped.
        wr(0, 6'h24, 64'd17);
        wr(0, 6'h25, 64'hFFFF_FFE3);
        rd(0, 6'h25, 64'd3, "sel5 truncated");
        ev = '1;
        idle();
        idle();
        ev = '0;
        rd(0, 6'h04, 64'd0, "cnt4 sel above range");
        rd(0, 6'h05, 64'd6, "cnt5 event 2 x3 x2");

        // Control registers keep only NUM_COUNTERS bits.
        wr(0, 6'h30, 64'hFFFF);
        rd(0, 6'h30, 64'hFF, "inhibit width");
        wr(0, 6'h32, 64'hFFFF);
        rd(0, 6'h32, OVF ? 64'hFF : 64'h0, "enable width");

        // XLEN 32 instance: carry into the high half is not an overflow.
        wr(1, 6'h10, 64'd1);
        wr(1, 6'h00, 64'hFFFF_FFFF);
        wr(1, 6'h20, 64'd1);
        wr(1, 6'h32, 64'd1);
        ev32 = 8'h01;
        idle();
        ev32 = '0;
        rd(1, 6'h10, 64'd2, "x32 high half carry");
        rd(1, 6'h00, 64'd0, "x32 low half wrapped");
        rd(1, 6'h31, 64'd0, "x32 no overflow");
        irq_chk(1, 1'b0, "x32 irq quiet");
        wr(1, 6'h10, 64'hFFFF_FFFF);
        wr(1, 6'h00, 64'hFFFF_FFFF);
        ev32 = 8'h01;
        idle();
        ev32 = '0;
        rd(1, 6'h00, 64'd0, "x32 full wrap low");
        rd(1, 6'h10, 64'd0, "x32 full wrap high");
        rd(1, 6'h31, OVF ? 64'd1 : 64'd0, "x32 overflow status");
        irq_chk(1, OVF, "x32 irq");

        // Asynchronous reset mid-cycle clears everything.
        #3 rst = 1'b1;
        rd(0, 6'h02, 64'd0, "cnt2 async reset");
        rd(0, 6'h30, 64'd0, "inhibit async reset");
        irq_chk(1, 1'b0, "x32 irq async reset");
        rst = 1'b0;
        wr(0, 6'h20, 64'd1);
        ev[1:0] = 2'd1;
        idle();
        ev = '0;
        rd(0, 6'h00, 64'd1, "count after reset");

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised hardware performance-monitor counter bank for the CSR file. Each of `NUM_COUNTERS` counters is bound at run time to one of `NUM_EVENTS` event inputs through a writable event selector, can be individually inhibited, and flags wrap-around in a sticky overflow status that can raise an interrupt. The CSR file reaches it through the same single-cycle SRAM-like read/write port it already uses for performance counters.

## Interface
- `NUM_COUNTERS`, default 8: number of counters, 1..16.
- `NUM_EVENTS`, default 16: number of event inputs, 1..63.
- `CNT_WIDTH`, default 64: counter width, 32..64.
- `XLEN`, default 64: CSR data width, 32 or 64.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `debug_mode_i` in 1: core is in debug mode; suppresses counting.
- `addr_i` in 6: register address (map below).
- `we_i` in 1: write enable.
- `data_i` in XLEN: write data.
- `data_o` out XLEN: read data.
- `event_inc_i` in NUM_EVENTS*2: per-event increment this cycle, 0..3 (one 2-bit field per event, covers dual commit).
- `ovf_irq_o` out 1: overflow interrupt request (level).

## Operation
- Address map, `addr_i[5:4]`: `00` counter[i] low XLEN bits; `01` counter[i] bits above XLEN (only when XLEN=32, else reserved); `10` event selector[i]; `11` control: `0x30` inhibit mask, `0x31` overflow status, `0x32` overflow interrupt enable. `i = addr_i[3:0]`.
- Unmapped/reserved address or `i >= NUM_COUNTERS`: reads 0, writes ignored.
- Selector width `SEL_W = $clog2(NUM_EVENTS+1)`; upper `data_i` bits dropped on write, read zero-extended. Value 0 = no event; k in 1..NUM_EVENTS = event k-1; k > NUM_EVENTS = no event.
- Per cycle, counter i adds the selected 2-bit increment unless `debug_mode_i` or inhibit bit i is set.
- Arithmetic modulo 2^CNT_WIDTH; carry out of bit CNT_WIDTH-1 is the overflow event for that counter.
- Write to a counter (either half) replaces that half; the increment for that counter is discarded in that cycle (write wins) and no overflow is flagged for it.
- Write to a selector/inhibit takes effect for counting from the next cycle.
- Read is combinational from current state (write-after-read: same-cycle read returns pre-write value).
- Control registers: only bits [NUM_COUNTERS-1:0] implemented; others read 0.

## Timing
- Reset: all counters, selectors, inhibit, overflow status, interrupt enable = 0; `ovf_irq_o` = 0; `data_o` = 0 (follows state).
- Reset asserted mid-operation clears all state asynchronously; first count after deassertion occurs at the first clock edge with `rst_i` low.
- Event sampled at edge N appears in counter read at cycle N+1 (1-cycle latency).
- Overflow on edge N sets status bit at N; `ovf_irq_o` high from cycle N+1 while `|(status & enable)`.
- Simultaneous overflow set and software write to status in one cycle: set wins for that bit.
- `debug_mode_i` and inhibit freeze counters; writes still accepted.

## Configuration
- `HPM_OVF_IRQ_EN` defined: overflow status (`0x31`, write-1-to-clear), interrupt enable (`0x32`) and `ovf_irq_o` implemented as above.
- Not defined: no overflow status/enable storage; `0x31`/`0x32` read 0, writes ignored; `ovf_irq_o` tied 0; counters still wrap silently.

## Test plan
- Reset, then read every address -> all return 0, `ovf_irq_o` = 0.
- Selector[2]=5, drive `event_inc_i[4]`=2 for 10 cycles -> counter[2] reads 20; counter[0] (selector 0) reads 0.
- Counter[1] written to 2^CNT_WIDTH-1, enable bit 1, selector event 0 increment 3 -> counter[1] reads 2, status bit1=1, `ovf_irq_o`=1 next cycle; write 0x2 to `0x31` -> irq drops.
- Counter[3] counting, same-cycle write 0x100 and increment 1 -> reads 0x100 next cycle; subsequent cycle 0x101.
- Inhibit bit 0 set or `debug_mode_i`=1 for 5 active-event cycles -> counter[0] unchanged; released -> resumes +1/cycle.
- XLEN=32, CNT_WIDTH=64: write high half 0x1, low 0xFFFFFFFF, one increment -> high reads 0x2, low 0x0, no overflow flagged.
